// File: rtl/mem_access_module.sv
// RV32I memory-access stage: load/store over a request/response data port, load alignment and extension, MEM/WB register.
// Optional build macro MISALIGN_TRAP_EN: misaligned halfword/word accesses are flagged and retired without a memory request.
module mem_access_module (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic [31:0] ALUout_x,
    input  logic [31:0] rs2_data_x,
    input  logic [31:0] pc_x,
    input  logic [4:0]  rd_x,
    input  logic        regwrite_x,
    input  logic [1:0]  WBsel_x,
    input  logic        mem_rd_x,
    input  logic        mem_wr_x,
    input  logic [2:0]  funct3_x,
    output logic        stall_m,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ready,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic [31:0] data_r,
    output logic [31:0] ALUout,
    output logic [31:0] pc_m,
    output logic [1:0]  WBsel,
    output logic [4:0]  rd_w,
    output logic        regwrite_w,
    output logic        misalign_w
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_R} state_t;
    state_t state;

    logic [1:0]  lane;
    logic        mem_op;
    logic        ld_byte, ld_half;
    logic        st_byte, st_half;
    logic        trap;
    logic        access;
    logic [31:0] st_wdata;
    logic [3:0]  st_be;
    logic [7:0]  ld_b;
    logic [15:0] ld_h;
    logic [31:0] load_ext;
    logic        accept;
    logic        commit_mem;
    logic        commit_plain;

    assign lane = ALUout_x[1:0];

    // Store and load size decode differ: every non-SB/SH store code is a word.
    always_comb begin
        mem_op  = ex_valid & (mem_rd_x | mem_wr_x);
        ld_byte = (funct3_x[1:0] == 2'b00);
        ld_half = (funct3_x[1:0] == 2'b01);
        st_byte = (funct3_x == 3'b000);
        st_half = (funct3_x == 3'b001);
    end

`ifdef MISALIGN_TRAP_EN
    logic is_half, is_word, misaligned;
    always_comb begin
        is_half    = mem_wr_x ? st_half : ld_half;
        is_word    = mem_wr_x ? !(st_byte | st_half) : !(ld_byte | ld_half);
        misaligned = (is_half & lane[0]) | (is_word & (lane != 2'b00));
        trap       = mem_op & misaligned;
    end
`else
    assign trap = 1'b0;
`endif

    assign access = mem_op & ~trap;

    always_comb begin
        st_wdata = rs2_data_x;
        st_be    = 4'b1111;
        if (st_byte) begin
            st_wdata = {4{rs2_data_x[7:0]}};
            st_be    = 4'b0001 << lane;
        end else if (st_half) begin
            st_wdata = {2{rs2_data_x[15:0]}};
            st_be    = 4'b0011 << {lane[1], 1'b0};
        end
    end

    always_comb begin
        case (lane)
            2'd0:    ld_b = dmem_rdata[7:0];
            2'd1:    ld_b = dmem_rdata[15:8];
            2'd2:    ld_b = dmem_rdata[23:16];
            default: ld_b = dmem_rdata[31:24];
        endcase
        ld_h = lane[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        if (ld_byte)
            load_ext = {{24{~funct3_x[2] & ld_b[7]}}, ld_b};
        else if (ld_half)
            load_ext = {{16{~funct3_x[2] & ld_h[15]}}, ld_h};
        else
            load_ext = dmem_rdata;
    end

    // Request fields come straight from the execute inputs, which stall_m holds stable while in REQ.
    assign dmem_req   = rst_n & access & (state != WAIT_R);
    assign dmem_we    = dmem_req & mem_wr_x;
    assign dmem_addr  = dmem_req ? {ALUout_x[31:2], 2'b00} : '0;
    assign dmem_wdata = (dmem_req & mem_wr_x) ? st_wdata : '0;
    assign dmem_be    = (dmem_req & mem_wr_x) ? st_be : '0;

    assign accept       = dmem_req & dmem_ready;
    assign commit_mem   = (accept & mem_wr_x) | ((state == WAIT_R) & dmem_rvalid);
    assign commit_plain = (state == IDLE) & ex_valid & ~access;
    assign stall_m      = rst_n & access & ~commit_mem;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            wb_valid   <= 1'b0;
            data_r     <= '0;
            ALUout     <= '0;
            pc_m       <= '0;
            WBsel      <= '0;
            rd_w       <= '0;
            regwrite_w <= 1'b0;
            misalign_w <= 1'b0;
        end else begin
            case (state)
                IDLE, REQ: begin
                    if (dmem_req) begin
                        if (!dmem_ready)
                            state <= REQ;
                        else if (mem_rd_x)
                            state <= WAIT_R;
                        else
                            state <= IDLE;
                    end else begin
                        state <= IDLE;
                    end
                end
                WAIT_R: begin
                    if (dmem_rvalid)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (commit_mem | commit_plain) begin
                wb_valid   <= 1'b1;
                data_r     <= (state == WAIT_R) ? load_ext : '0;
                ALUout     <= ALUout_x;
                pc_m       <= pc_x;
                WBsel      <= WBsel_x;
                rd_w       <= rd_x;
                regwrite_w <= regwrite_x & ~trap;
                misalign_w <= trap;
            end else begin
                wb_valid   <= 1'b0;
                regwrite_w <= 1'b0;
            end
        end
    end

endmodule

// File: doc/mem_access_module.md
# mem_access_module

Memory-access stage of the five-stage RV32I pipeline, between the execute stage and the writeback select stage. Takes the execute result, runs load/store traffic on a request/response data-memory port, aligns and sign/zero-extends load data, and registers the MEM/WB pipeline values that writeback consumes. Stalls upstream while a memory transaction is outstanding and inserts a bubble toward writeback.

## Interface
- No parameters. Datapath fixed at 32 bits, register index at 5 bits.
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- ex_valid  in  1  execute stage presents a valid instruction
- ALUout_x  in  32  ALU result / effective address
- rs2_data_x  in  32  store data
- pc_x  in  32  instruction PC
- rd_x  in  5  destination register
- regwrite_x  in  1  instruction writes rd
- WBsel_x  in  2  writeback select (00 load data, 01 ALU, 10 PC+4)
- mem_rd_x, mem_wr_x  in  1 each  load / store (never both)
- funct3_x  in  3  access size/sign
- stall_m  out  1  hold execute-stage inputs stable
- dmem_req  out  1  request valid
- dmem_we  out  1  1 = store
- dmem_addr  out  32  word-aligned address
- dmem_wdata  out  32  lane-replicated store data
- dmem_be  out  4  byte enables
- dmem_ready  in  1  request accepted this cycle
- dmem_rvalid  in  1  load data valid
- dmem_rdata  in  32  load word
- wb_valid  out  1  MEM/WB register holds a valid instruction
- data_r, ALUout, pc_m  out  32 each  registered load data / ALU result / PC
- WBsel  out  2  registered writeback select
- rd_w  out  5  registered destination
- regwrite_w  out  1  registered write enable (forced 0 when wb_valid=0)
- misalign_w  out  1  registered misaligned-access flag

## Operation
- FSM: IDLE, REQ (awaiting dmem_ready), WAIT_R (awaiting dmem_rvalid).
- Non-memory op (ex_valid, no mem_rd/mem_wr): MEM/WB captures inputs next edge; data_r=0; stall_m=0.
- Memory op in IDLE: dmem_req=1 combinationally. Not accepted -> REQ. Accepted store -> commit, stay IDLE. Accepted load -> WAIT_R.
- REQ: dmem_req held with identical addr/we/wdata/be until dmem_ready; then as IDLE.
- WAIT_R: dmem_req=0; on dmem_rvalid commit extended data to data_r, -> IDLE.
- stall_m=1 for a valid memory op in every cycle except its commit cycle.
- wb_valid=0 and regwrite_w=0 on every edge where nothing commits (bubble); other MEM/WB fields hold.
- dmem_addr={ALUout_x[31:2],2'b00}; lane=ALUout_x[1:0].
- Stores: SB(000) wdata={4{rs2[7:0]}}, be=0001<<lane; SH(001) wdata={2{rs2[15:0]}}, be=0011<<{lane[1],0}; SW(010 and reserved codes) be=1111.
- Loads: LB/LBU(000/100) byte at lane, sign/zero-extended; LH/LHU(001/101) halfword at lane[1]; LW(010, reserved codes) full word.
- dmem_rvalid outside WAIT_R ignored.

## Timing
- Reset: state IDLE; all outputs 0; dmem_req forced 0 while rst_n low.
- Non-memory op: 1-cycle latency to MEM/WB.
- Store accepted cycle N: commit edge end of N, zero stall if ready in N.
- Load accepted cycle N, rvalid earliest N+1: commit edge end of N+1; stall_m high in N, low in N+1.
- Memory slave must not assert dmem_rvalid in the acceptance cycle.
- Reset mid-transaction: FSM aborts to IDLE; later rvalid ignored; no commit.

## Configuration
- MISALIGN_TRAP_EN defined: LH/LHU/SH with lane[0]=1, or word with lane!=0, issue no dmem request, commit in 1 cycle with wb_valid=1, regwrite_w=0, misalign_w=1, pc_m=pc_x, ALUout=address; stall_m=0.
- Undefined: misalign_w tied 0; offending low address bits ignored (halfword uses lane[1], word uses lane 0); access proceeds normally.

## Test plan
- Reset, ALU op ALUout_x=0x1234, rd_x=5 -> next edge wb_valid=1, ALUout=0x1234, rd_w=5, stall_m never set.
- SB addr 0x103, rs2=0xAABBCCDD, ready same cycle -> dmem_be=1000, dmem_wdata=0xDDDDDDDD, dmem_addr=0x100, no stall.
- LB addr 0x102, ready after 2 cycles, rvalid 3 cycles later, rdata=0x00800000 -> data_r=0xFFFFFF80; stall_m high until rvalid cycle; bubbles (wb_valid=0) meanwhile.
- LHU addr 0x202, rdata=0xBEEF1234, immediate ready/rvalid -> data_r=0x0000BEEF, two-cycle occupancy.
- With MISALIGN_TRAP_EN: LW addr 0x301 -> dmem_req stays 0, misalign_w=1, regwrite_w=0; without it: access to 0x300, data_r=rdata.
- Assert rst_n=0 in WAIT_R -> outputs 0 immediately; post-reset rvalid pulse produces no commit.
